// File: rtl/fifo_mem_param_if.sv
// Producer/consumer bundle for fifo_mem_param.
// master drives requests and write data; slave returns data, level and flags.
interface fifo_mem_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic                  rd;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_threshold;
  logic                  fifo_almost_empty;
  logic                  fifo_overflow;
  logic                  fifo_underflow;
  logic [ADDR_WIDTH:0]   fill_count;

  modport master (
    output wr, rd, err_clr, data_in,
    input  data_out, fifo_full, fifo_empty,
    input  fifo_threshold, fifo_almost_empty,
    input  fifo_overflow, fifo_underflow,
    input  fill_count
  );

  modport slave (
    input  wr, rd, err_clr, data_in,
    output data_out, fifo_full, fifo_empty,
    output fifo_threshold, fifo_almost_empty,
    output fifo_overflow, fifo_underflow,
    output fill_count
  );
endinterface

// File: rtl/fifo_mem_param.sv
// Parametrised synchronous FIFO with level flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through read mode.
module fifo_mem_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_mem_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic [PW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  thr;
  logic                  aempty;
  logic                  ovf;
  logic                  unf;
  logic                  rd_ok;
  logic                  wr_ok;

  assign rd_ok = bus.rd & ~empty;
  assign wr_ok = bus.wr & (~full | rd_ok);

  assign count_nxt = count + PW'(wr_ok)
                   - PW'(rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      thr    <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_ok);
      rd_ptr <= rd_ptr + PW'(rd_ok);
      count  <= count_nxt;
      full   <= count_nxt == PW'(DEPTH);
      empty  <= count_nxt == '0;
      thr    <= count_nxt >= PW'(AFULL_LEVEL);
      aempty <= count_nxt <= PW'(AEMPTY_LEVEL);
      // a new error in the clear cycle keeps the flag set
      ovf    <= (bus.wr & ~wr_ok)
              | (ovf & ~bus.err_clr);
      unf    <= (bus.rd & ~rd_ok)
              | (unf & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  logic [PW-1:0] avail;
  logic [PW-1:0] rd_ptr_nxt;
  logic          bypass;

  assign avail      = count - PW'(rd_ok);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_ok);
  // new head is the word being written this edge
  assign bypass     = (avail == '0) & wr_ok;

  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (bypass)
      dout <= bus.data_in;
    else if (avail != '0)
      dout <= mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (rd_ok)
      dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
`endif

  assign bus.data_out          = dout;
  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_threshold    = thr;
  assign bus.fifo_almost_empty = aempty;
  assign bus.fifo_overflow     = ovf;
  assign bus.fifo_underflow    = unf;
  assign bus.fill_count        = count;
endmodule
